// File: rtl/sha512_sched.sv
// sha512_sched
//   Round-robin scheduler sharing one SHA-512 core among NUM_REQ requesters.
//   Each requester streams pre-padded 1024-bit blocks of one message. The last
//   block is flagged. The grant is held for a whole message. The first block
//   is issued with core_init and later blocks with core_next. The final digest
//   is returned tagged with the owning requester id.
//
// Parameters
//   NUM_REQ        number of requesters (1..16)
//   ID_W           width of the digest id tag
//   TIMEOUT_CYCLES WAIT watchdog limit (only with SHA512_SCHED_TIMEOUT_EN)
//
// Optional feature
//   `define SHA512_SCHED_TIMEOUT_EN enables the WAIT watchdog and a sticky
//   timeout_err. When the macro is undefined, timeout_err is tied to 0.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req_valid/ready   per-requester block handshake (ready is at most one-hot)
//   req_block         flat blocks, requester i at [i*1024 +: 1024]
//   req_last          block is the final block of its message
//   core_init/next    one-cycle command pulses to the core
//   core_block        registered block presented to the core
//   core_ready        core idle
//   core_digest       core digest
//   core_digest_valid core digest valid
//   dgst_valid/id/data/ready  final digest output handshake
//   busy              scheduler not idle
//   timeout_err       sticky watchdog flag
module sha512_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*1024-1:0] req_block,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    core_init,
  output logic                    core_next,
  output logic [1023:0]           core_block,
  input  logic                    core_ready,
  input  logic [511:0]            core_digest,
  input  logic                    core_digest_valid,
  output logic                    dgst_valid,
  output logic [ID_W-1:0]         dgst_id,
  output logic [511:0]            dgst_data,
  input  logic                    dgst_ready,
  output logic                    busy,
  output logic                    timeout_err
);

  if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sha512_sched: parameter out of range");
  end

  localparam int unsigned NREQ = unsigned'(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    WAIT,
    OUT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] grant_nxt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] pick;
  logic            found;
  logic            first;
  logic            last_q;
  logic            done;
  logic            wd_hit;
  int unsigned     idx;
  logic [1023:0]   blk_slot [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign blk_slot[gi] = req_block[gi*1024 +: 1024];
  end

  assign done = core_ready && core_digest_valid;

  // First valid requester searching upward from ptr with wrap.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_nxt = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (found && core_ready) state_nxt = ISSUE;
      ISSUE: if (req_valid[grant]) state_nxt = ARM;
      ARM:   state_nxt = WAIT;
      WAIT: begin
        if (done)        state_nxt = last_q ? OUT : ISSUE;
        else if (wd_hit) state_nxt = IDLE;
      end
      OUT:   if (dgst_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs
  always_comb begin
    req_ready = '0;
    if (state == ISSUE) req_ready[grant] = 1'b1;
    busy = (state != IDLE);
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      ptr        <= '0;
      first      <= 1'b1;
      last_q     <= 1'b0;
      core_init  <= 1'b0;
      core_next  <= 1'b0;
      core_block <= '0;
      dgst_valid <= 1'b0;
      dgst_id    <= '0;
      dgst_data  <= '0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found && core_ready) begin
            grant <= pick;
            first <= 1'b1;
          end
        end
        ISSUE: begin
          if (req_valid[grant]) begin
            core_block <= blk_slot[grant];
            last_q     <= req_last[grant];
            core_init  <= first;
            core_next  <= !first;
            first      <= 1'b0;
          end
        end
        WAIT: begin
          if (done) begin
            if (last_q) begin
              dgst_data  <= core_digest;
              dgst_id    <= grant;
              dgst_valid <= 1'b1;
            end
          end else if (wd_hit) begin
            ptr <= grant_nxt;
          end
        end
        OUT: begin
          if (dgst_ready) begin
            dgst_valid <= 1'b0;
            ptr        <= grant_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA512_SCHED_TIMEOUT_EN
  logic [31:0] wdog;
  logic        timeout_q;

  // ARM always precedes WAIT, so clearing there restarts the count on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ARM)       wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 32'd1;
      if (wd_hit) timeout_q <= 1'b1;
    end
  end

  assign wd_hit      = (state == WAIT) && !done && (wdog == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_sched.sv
// tb_sha512_sched
//   Directed bench for sha512_sched with a behavioural core stand-in that
//   returns the known SHA-512 digests for the reference blocks it recognises.
module tb_sha512_sched;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*1024-1:0] req_block = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic              core_init, core_next;
  logic [1023:0]     core_block;
  logic              core_ready;
  logic [511:0]      core_digest;
  logic              core_digest_valid;
  logic              dgst_valid;
  logic [IW-1:0]     dgst_id;
  logic [511:0]      dgst_data;
  logic              dgst_ready = 1'b1;
  logic              busy, timeout_err;

  always #5 clk = ~clk;

  sha512_sched #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_block(req_block), .req_last(req_last), .req_ready(req_ready),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid),
    .dgst_valid(dgst_valid), .dgst_id(dgst_id), .dgst_data(dgst_data), .dgst_ready(dgst_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Reference vectors
  logic [1023:0] abc_blk, m2_b0, m2_b1;
  logic [895:0]  m2_msg;
  logic [511:0]  abc_dig, m2_dig, m2_mid, bad_dig;

  // Core stand-in
  logic [511:0] h_st;
  int           cnt;
  logic         hang = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      core_ready <= 1'b1; core_digest_valid <= 1'b0; core_digest <= '0; cnt <= 0; h_st <= '0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0; core_digest_valid <= 1'b0; cnt <= LAT;
      if (core_init)
        h_st <= (core_block == abc_blk) ? abc_dig : (core_block == m2_b0) ? m2_mid : bad_dig;
      else
        h_st <= (h_st == m2_mid && core_block == m2_b1) ? m2_dig : bad_dig;
    end else if (!core_ready && !hang) begin
      if (cnt > 1) cnt <= cnt - 1;
      else begin core_ready <= 1'b1; core_digest_valid <= 1'b1; core_digest <= h_st; end
    end
  end

  // Requester model and observation state
  logic [1023:0] blk [N][2];
  logic          lst [N][2];
  int            nblk [N];
  int            sent [N];
  logic          en [N];
  logic          hold [N];
  logic [IW-1:0] got_id [$];
  logic [511:0]  got_dat [$];
  int   init_cnt, next_cnt, both_err, multi_err, busy_cmd_err, onehot_err, early3;
  logic prev_cmd, watch3;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && !hold[i] && sent[i] < nblk[i]) begin
        req_valid[i] = 1'b1;
        req_block[i*1024 +: 1024] = blk[i][sent[i]];
        req_last[i] = lst[i][sent[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_block[i*1024 +: 1024] = '0;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input int nb, input logic [1023:0] b0, input logic l0,
                         input logic [1023:0] b1, input logic l1);
    blk[i][0] = b0; lst[i][0] = l0; blk[i][1] = b1; lst[i][1] = l1;
    nblk[i] = nb; sent[i] = 0; en[i] = 1'b1; hold[i] = 1'b0;
    drive_reqs();
  endtask

  // Observe at the current negedge, then advance one clock.
  task automatic tick();
    logic [N-1:0] fire;
    fire = req_valid & req_ready;
    if (core_init && core_next) both_err++;
    if ((core_init || core_next) && prev_cmd) multi_err++;
    if ((core_init || core_next) && !core_ready) busy_cmd_err++;
    prev_cmd = core_init || core_next;
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
    if ($countones(req_ready) > 1 || (req_ready != '0 && !busy)) onehot_err++;
    if (dgst_valid && dgst_ready) begin
      got_id.push_back(dgst_id);
      got_dat.push_back(dgst_data);
    end
    if (watch3 && fire[3] && got_id.size() == 0) early3++;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) if (fire[i]) sent[i]++;
    drive_reqs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; hold[i] = 1'b0; sent[i] = 0; nblk[i] = 0;
    end
    drive_reqs();
    dgst_ready = 1'b1; hang = 1'b0; watch3 = 1'b0; early3 = 0;
    got_id.delete(); got_dat.delete();
    init_cnt = 0; next_cnt = 0; prev_cmd = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_digests(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (got_id.size() < n && c < budget) begin tick(); c++; end
    check(tag, got_id.size(), n);
  endtask

  initial begin
    int c, bad;
    int exp_ids [5];
    exp_ids = '{0, 1, 2, 3, 1};
    both_err = 0; multi_err = 0; busy_cmd_err = 0; onehot_err = 0;
    for (int i = 0; i < N; i++) begin en[i] = 1'b0; hold[i] = 1'b0; sent[i] = 0; nblk[i] = 0; end

    abc_blk = '0; abc_blk[1023:992] = 32'h61626380; abc_blk[7:0] = 8'h18;
    m2_msg  = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
    m2_b0   = {m2_msg, 8'h80, 120'h0};
    m2_b1   = {896'h0, 128'd896};
    abc_dig = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
    m2_dig  = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;
    m2_mid  = 512'h1;
    bad_dig = {16{32'hdeadbeef}};

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_ctl", {req_ready, core_init, core_next, dgst_valid, dgst_id, busy, timeout_err}, '0);
    check("rst_blk", core_block[1023:512] | core_block[511:0], '0);
    check("rst_dgst", dgst_data, '0);

    // Single-block "abc" from requester 0
    do_reset();
    set_req(0, 1, abc_blk, 1'b1, '0, 1'b0);
    run_digests(1, 200, "t1_count");
    check("t1_id", got_id[0], 0);
    check("t1_data", got_dat[0], abc_dig);
    check("t1_init", init_cnt, 1);
    check("t1_next", next_cnt, 0);
    tick();
    check("t1_idle", busy, 0);

    // Two-block message from requester 2
    do_reset();
    set_req(2, 2, m2_b0, 1'b0, m2_b1, 1'b1);
    run_digests(1, 300, "t2_count");
    check("t2_id", got_id[0], 2);
    check("t2_data", got_dat[0], m2_dig);
    check("t2_init", init_cnt, 1);
    check("t2_next", next_cnt, 1);

    // All requesters valid; requester 1 re-requests after its turn
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, abc_blk, 1'b1, '0, 1'b0);
    set_req(1, 2, abc_blk, 1'b1, abc_blk, 1'b1);
    run_digests(5, 600, "t3_count");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_id%0d", k), got_id[k], exp_ids[k]);
      check($sformatf("t3_data%0d", k), got_dat[k], abc_dig);
    end
    check("t3_init", init_cnt, 5);

    // Requester 1 pauses between blocks; requester 3 must wait
    do_reset();
    set_req(1, 2, m2_b0, 1'b0, m2_b1, 1'b1);
    set_req(3, 1, abc_blk, 1'b1, '0, 1'b0);
    watch3 = 1'b1;
    c = 0;
    while (sent[1] == 0 && c < 100) begin tick(); c++; end
    check("t4_first_blk", sent[1], 1);
    hold[1] = 1'b1; drive_reqs();
    repeat (10) tick();
    check("t4_hold_rr", req_ready, 4'b0010);
    check("t4_no_dgst", got_id.size(), 0);
    hold[1] = 1'b0; drive_reqs();
    run_digests(2, 300, "t4_count");
    check("t4_id0", got_id[0], 1);
    check("t4_data0", got_dat[0], m2_dig);
    check("t4_id1", got_id[1], 3);
    check("t4_data1", got_dat[1], abc_dig);
    check("t4_early3", early3, 0);
    watch3 = 1'b0;

    // Output back-pressure
    do_reset();
    dgst_ready = 1'b0;
    set_req(0, 1, abc_blk, 1'b1, '0, 1'b0);
    c = 0;
    while (!dgst_valid && c < 200) begin tick(); c++; end
    check("t5_valid", dgst_valid, 1);
    set_req(2, 1, abc_blk, 1'b1, '0, 1'b0);
    bad = 0;
    repeat (20) begin
      if (!dgst_valid || dgst_id != 0 || dgst_data != abc_dig || req_ready != '0 || !busy) bad++;
      tick();
    end
    check("t5_stable", bad, 0);
    dgst_ready = 1'b1;
    tick();
    check("t5_busy", busy, 0);
    check("t5_vclr", dgst_valid, 0);
    run_digests(2, 200, "t5_count");
    check("t5_id0", got_id[0], 0);
    check("t5_id1", got_id[1], 2);

    // Reset while waiting on the core
    do_reset();
    set_req(0, 1, abc_blk, 1'b1, '0, 1'b0);
    c = 0;
    while (init_cnt == 0 && c < 50) begin tick(); c++; end
    check("t6_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_ctl", {req_ready, core_init, core_next, dgst_valid, dgst_id, busy, timeout_err}, '0);
    check("t6_rst_dgst", dgst_data, '0);
    @(negedge clk);
    reset = 1'b0;
    got_id.delete(); got_dat.delete();
    bad = 0;
    repeat (20) begin
      if (dgst_valid) bad++;
      tick();
    end
    check("t6_no_dgst", bad + got_id.size(), 0);

    // Core that never finishes
    do_reset();
    set_req(0, 1, abc_blk, 1'b1, '0, 1'b0);
    hang = 1'b1;
    c = 0;
    while (init_cnt == 0 && c < 50) begin tick(); c++; end
`ifdef SHA512_SCHED_TIMEOUT_EN
    repeat (15) tick();
    check("t7_not_yet", timeout_err, 0);
    tick();
    check("t7_tmo", timeout_err, 1);
    check("t7_busy", busy, 0);
    check("t7_no_dv", dgst_valid, 0);
    repeat (5) tick();
    check("t7_sticky", timeout_err, 1);
    check("t7_no_dgst", got_id.size(), 0);
`else
    repeat (40) tick();
    check("t7_no_tmo", timeout_err, 0);
    check("t7_still_busy", busy, 1);
`endif

    check("both_cmd", both_err, 0);
    check("multi_cyc_cmd", multi_err, 0);
    check("cmd_while_busy", busy_cmd_err, 0);
    check("ready_onehot", onehot_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
